// File: rtl/mult_pkg.sv
// mult_pkg: shared widths and FSM state type for the 8-bit shift-add multiplier
package mult_pkg;
  localparam int N_BITS = 8;
  localparam int CNT_W  = 3;
  typedef enum logic [1:0] {IDLE, CALC, DONE} estado_t;
endpackage

// File: rtl/multiplicador_8bits_if.sv
// multiplicador_8bits_if: start/operand/result bundle between requester and multiplier
interface multiplicador_8bits_if;
  import mult_pkg::*;
  logic                  inicio;
  logic [N_BITS-1:0]     A;
  logic [N_BITS-1:0]     B;
  logic                  listo;
  logic                  valido;
  logic [2*N_BITS-1:0]   P;
  modport master (output inicio, A, B, input listo, valido, P);
  modport slave  (input inicio, A, B, output listo, valido, P);
endinterface

// File: rtl/sumador_8bits.sv
// sumador_8bits: 8-bit ripple-carry adder built from full-adder cells
module sumador_8bits
  import mult_pkg::*;
(
  input  logic [N_BITS-1:0] a_i,
  input  logic [N_BITS-1:0] b_i,
  input  logic              ci_i,
  output logic [N_BITS-1:0] s_o,
  output logic              co_o
);
  logic [N_BITS:0] c;
  assign c[0] = ci_i;
  assign co_o = c[N_BITS];
  for (genvar i = 0; i < N_BITS; i++) begin : g_fa
    assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end
endmodule

// File: rtl/multiplicador_8bits.sv
// multiplicador_8bits: sequential shift-add 8x8 unsigned multiplier, 8 CALC cycles per product.
// Optional MULT_ZERO_BYPASS_EN: zero operands skip CALC and finish in one cycle.
module multiplicador_8bits
  import mult_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  multiplicador_8bits_if.slave  bus
);
  estado_t             st_q, st_d;
  logic [N_BITS-1:0]   m_q, m_d, q_q, q_d, acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*N_BITS-1:0] p_q, p_d;
  logic                valido_q, valido_d;
  logic [N_BITS-1:0]   addend, sum;
  logic                co;
  assign addend = q_q[0] ? m_q : '0;
  sumador_8bits u_sum (.a_i(acc_q), .b_i(addend), .ci_i(1'b0), .s_o(sum), .co_o(co));
  assign bus.listo  = (st_q == IDLE);
  assign bus.valido = valido_q;
  assign bus.P      = p_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= IDLE;
      m_q      <= '0;
      q_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      p_q      <= '0;
      valido_q <= 1'b0;
    end else begin
      st_q     <= st_d;
      m_q      <= m_d;
      q_q      <= q_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      valido_q <= valido_d;
    end
  end
  always_comb begin
    st_d     = st_q;
    m_d      = m_q;
    q_d      = q_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    valido_d = 1'b0;
    case (st_q)
      IDLE: if (bus.inicio) begin
        m_d   = bus.A;
        q_d   = bus.B;
        acc_d = '0;
        cnt_d = '0;
        st_d  = CALC;
`ifdef MULT_ZERO_BYPASS_EN
        if (bus.A == '0 || bus.B == '0) begin
          st_d     = DONE;
          p_d      = '0;
          valido_d = 1'b1;
        end
`endif
      end
      CALC: begin
        // carry-out becomes the new MSB as {Co,sum,Q} shifts right by one
        acc_d = {co, sum[N_BITS-1:1]};
        q_d   = {sum[0], q_q[N_BITS-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(N_BITS - 1)) begin
          st_d     = DONE;
          p_d      = {co, sum, q_q[N_BITS-1:1]};
          valido_d = 1'b1;
        end
      end
      DONE:    st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_multiplicador_8bits.sv
// tb_multiplicador_8bits: randomized and directed checks against an arithmetic reference model
module tb_multiplicador_8bits;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  multiplicador_8bits_if bus ();
  multiplicador_8bits dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  function automatic int exp_lat(logic [7:0] a, logic [7:0] b);
`ifdef MULT_ZERO_BYPASS_EN
    return (a == 8'h00 || b == 8'h00) ? 0 : 8;
`else
    return 8;
`endif
  endfunction

  task automatic start(input logic [7:0] a, input logic [7:0] b, input bit hold);
    int n = 0;
    @(negedge clk);
    while (!bus.listo && n < 20) begin @(negedge clk); n++; end
    bus.inicio = 1'b1; bus.A = a; bus.B = b;
    @(posedge clk); #1;
    if (!hold) bus.inicio = 1'b0;
  endtask

  task automatic wait_valid(output int cycles, output bit got);
    cycles = 0;
    got = bus.valido;
    while (!got && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
      got = bus.valido;
    end
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if (bus.listo !== 1'b1 || bus.valido !== 1'b0 || bus.P !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset: listo=%b valido=%b P=%h, want listo=1 valido=0 P=0000", bus.listo, bus.valido, bus.P);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_max();
    int lo = 0, first = -1, pulses = 0;
    start(8'hFF, 8'hFF, 0);
    for (int k = 0; k < 12; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (!bus.listo) lo++;
      if (bus.valido) begin
        pulses++;
        if (first < 0) begin
          first = k;
          vectors++;
          if (bus.P !== 16'hFE01) begin miscompares++; $display("FAIL max_p: P=%h want FE01", bus.P); end
        end
      end
    end
    vectors++;
    if (first != 8) begin miscompares++; $display("FAIL max_latency: %0d want 8", first); end
    vectors++;
    if (lo != 9) begin miscompares++; $display("FAIL max_listo_low: %0d cycles want 9", lo); end
    vectors++;
    if (pulses != 1) begin miscompares++; $display("FAIL max_pulses: %0d want 1", pulses); end
  endtask

  task automatic test_input_change();
    int c; bit g;
    start(8'h0D, 8'h0B, 0);
    bus.A = 8'h00; bus.B = 8'h00;
    wait_valid(c, g);
    vectors++;
    if (!g || bus.P !== 16'h008F) begin miscompares++; $display("FAIL input_change: got=%b P=%h want 008F", g, bus.P); end
  endtask

  task automatic test_ignore_inicio();
    int c, extra = 0; bit g;
    start(8'h12, 8'h34, 0);
    repeat (3) @(negedge clk);
    bus.inicio = 1'b1; bus.A = 8'h01; bus.B = 8'h01;
    @(negedge clk); bus.inicio = 1'b0;
    wait_valid(c, g);
    vectors++;
    if (!g || bus.P !== 16'h03A8) begin miscompares++; $display("FAIL ignore_p: got=%b P=%h want 03A8", g, bus.P); end
    repeat (20) begin @(posedge clk); #1; if (bus.valido) extra++; end
    vectors++;
    if (extra != 0) begin miscompares++; $display("FAIL ignore_extra: %0d extra pulses want 0", extra); end
  endtask

  task automatic test_reset_abort();
    int c, pulses = 0; bit g;
    start(8'h80, 8'h02, 0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.P !== 16'h0000 || bus.listo !== 1'b1 || bus.valido !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_reset: P=%h listo=%b valido=%b want 0000/1/0", bus.P, bus.listo, bus.valido);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (12) begin @(posedge clk); #1; if (bus.valido) pulses++; end
    vectors++;
    if (pulses != 0) begin miscompares++; $display("FAIL abort_pulse: %0d want 0", pulses); end
    start(8'h03, 8'h05, 0);
    wait_valid(c, g);
    vectors++;
    if (!g || bus.P !== 16'h000F || c != 8) begin miscompares++; $display("FAIL abort_restart: got=%b P=%h lat=%0d want 000F lat 8", g, bus.P, c); end
  endtask

  task automatic test_zero();
    int c; bit g;
    start(8'h00, 8'h37, 0);
    wait_valid(c, g);
    vectors++;
    if (!g || bus.P !== 16'h0000) begin miscompares++; $display("FAIL zero_p: got=%b P=%h want 0000", g, bus.P); end
    vectors++;
    if (c != exp_lat(8'h00, 8'h37)) begin miscompares++; $display("FAIL zero_latency: %0d want %0d", c, exp_lat(8'h00, 8'h37)); end
  endtask

  task automatic test_back_to_back();
    int c1, c2; bit g1, g2;
    start(8'h02, 8'h03, 1);
    bus.A = 8'h10; bus.B = 8'h10;
    wait_valid(c1, g1);
    vectors++;
    if (!g1 || bus.P !== 16'h0006 || c1 != 8) begin miscompares++; $display("FAIL b2b_first: got=%b P=%h lat=%0d want 0006 lat 8", g1, bus.P, c1); end
    @(posedge clk); #1;
    wait_valid(c2, g2);
    bus.inicio = 1'b0;
    vectors++;
    if (!g2 || bus.P !== 16'h0100) begin miscompares++; $display("FAIL b2b_second: got=%b P=%h want 0100", g2, bus.P); end
    vectors++;
    if (c2 + 1 != 10) begin miscompares++; $display("FAIL b2b_interval: %0d want 10", c2 + 1); end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    logic [15:0] want;
    int c; bit g;
    for (int n = 0; n < 30; n++) begin
      a = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      want = 16'(a) * 16'(b);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      start(a, b, 0);
      bus.A = 8'($urandom); bus.B = 8'($urandom);
      wait_valid(c, g);
      vectors++;
      if (!g || bus.P !== want || c != exp_lat(a, b)) begin
        miscompares++;
        $display("FAIL random %h*%h: got=%b P=%h lat=%0d want %h lat %0d", a, b, g, bus.P, c, want, exp_lat(a, b));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.inicio = 1'b0; bus.A = 8'h00; bus.B = 8'h00;
    test_reset();
    test_max();
    test_input_change();
    test_ignore_inicio();
    test_reset_abort();
    test_zero();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
